// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the five-stage pipeline: load-use, branch and
// data-memory wait handling plus saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int reg_addr_bits = 5,
  parameter int count_bits    = 16,
  parameter int mem_timeout   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [reg_addr_bits-1:0] id_rs1,
  input  logic [reg_addr_bits-1:0] id_rs2,
  input  logic                     id_uses_rs2,
  input  logic [reg_addr_bits-1:0] ex_rd,
  input  logic                     ex_mem_read,
  input  logic                     ex_branch_taken,
  input  logic                     mem_req,
  input  logic                     mem_ack,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     if_id_flush,
  output logic                     id_ex_write,
  output logic                     id_ex_flush,
  output logic                     ex_mem_write,
  output logic                     mem_wb_write,
  output logic                     mem_wb_bubble,
  output logic                     mem_error,
  output logic [count_bits-1:0]    stall_cycles,
  output logic [count_bits-1:0]    flush_count
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  localparam logic [count_bits-1:0] TMO =
    count_bits'(mem_timeout);

  logic [1:0]            state_q, state_d;
  logic [count_bits-1:0] wait_q, wait_d;
  logic                  err_q, err_d;
  logic [count_bits-1:0] stall_q, stall_d;
  logic [count_bits-1:0] flush_q, flush_d;

  logic load_use;
  logic freeze, halt, rules;
  logic br_fire, lu_fire;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    freeze  = 1'b0;
    halt    = 1'b0;
    rules   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = count_bits'(1);
        end else begin
          rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ack) begin
          freeze = 1'b1;
          wait_d = wait_q + count_bits'(1);
          if (wait_d >= TMO) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end else begin
          rules   = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end
      end
      HALT: begin
        halt  = 1'b1;
        err_d = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Branch outranks load-use: the dependent instruction is squashed anyway.
  assign br_fire = rules && ex_branch_taken;
  assign lu_fire = rules && !ex_branch_taken && load_use;

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      halt: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      br_fire: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      lu_fire: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_write   = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_write  = 1'b0;
      mem_wb_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && !halt && (stall_q != '1))
      stall_d = stall_q + count_bits'(1);
    if (br_fire && (flush_q != '1))
      flush_d = flush_q + count_bits'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign mem_error    = err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (count_bits=4,
// mem_timeout=4 so saturation and timeout are reachable quickly).
module tb_pipeline_hazard_controller;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ack;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write;
  logic       id_ex_flush, ex_mem_write, mem_wb_write, mem_wb_bubble;
  logic       mem_error;
  logic [3:0] stall_cycles, flush_count;
  logic [7:0] ctl;

  int checks = 0;
  int errors = 0;

  // {pc, ifw, iff, idw, idf, exw, mww, bubble}
  localparam logic [7:0] DEF   = 8'hD6;
  localparam logic [7:0] LU    = 8'h1E;
  localparam logic [7:0] BR    = 8'hFE;
  localparam logic [7:0] FRZ   = 8'h03;
  localparam logic [7:0] HLT   = 8'h01;
  localparam logic [7:0] RST   = 8'h29;

  pipeline_hazard_controller #(
    .reg_addr_bits(5),
    .count_bits(4),
    .mem_timeout(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write),
    .mem_wb_write(mem_wb_write),
    .mem_wb_bubble(mem_wb_bubble),
    .mem_error(mem_error),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_flush, ex_mem_write, mem_wb_write, mem_wb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== RST) begin
      errors++;
      $display("FAIL reset_ctl got %h want %h", ctl, RST);
    end
    checks++;
    if ({mem_error, stall_cycles, flush_count} !== 9'd0) begin
      errors++;
      $display("FAIL reset_regs got err=%b st=%0d fl=%0d want 0",
               mem_error, stall_cycles, flush_count);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== DEF) begin
      errors++;
      $display("FAIL post_reset_default got %h want %h", ctl, DEF);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    @(negedge clk);
    checks++;
    if (ctl !== LU) begin
      errors++;
      $display("FAIL load_use_ctl got %h want %h", ctl, LU);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL load_use_stall got %0d want 1", stall_cycles);
    end
    ex_mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== DEF) begin
      errors++;
      $display("FAIL load_use_release got %h want %h", ctl, DEF);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL load_use_hold got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_x0_rs2();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    @(negedge clk);
    checks++;
    if (ctl !== DEF) begin
      errors++;
      $display("FAIL rd_x0 got %h want %h", ctl, DEF);
    end
    ex_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    #1;
    checks++;
    if (ctl !== DEF) begin
      errors++;
      $display("FAIL rs2_unused got %h want %h", ctl, DEF);
    end
    id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl !== LU) begin
      errors++;
      $display("FAIL rs2_used got %h want %h", ctl, LU);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL rs2_stall got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_branch_over_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== BR) begin
      errors++;
      $display("FAIL branch_ctl got %h want %h", ctl, BR);
    end
    tick();
    idle();
    checks++;
    if ({flush_count, stall_cycles} !== {4'd1, 4'd0}) begin
      errors++;
      $display("FAIL branch_counts got fl=%0d st=%0d want fl=1 st=0",
               flush_count, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== FRZ) begin
        errors++;
        $display("FAIL mem_freeze%0d got %h want %h", i, ctl, FRZ);
      end
      tick();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== DEF) begin
      errors++;
      $display("FAIL mem_ack_ctl got %h want %h", ctl, DEF);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd3) begin
      errors++;
      $display("FAIL mem_stall_cnt got %0d want 3", stall_cycles);
    end
    // Back in RUN: a new miss freezes, and an ack-in-same-cycle does not
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== DEF) begin
      errors++;
      $display("FAIL mem_same_cycle_ack got %h want %h", ctl, DEF);
    end
    mem_ack = 1'b0;
    #1;
    checks++;
    if (ctl !== FRZ) begin
      errors++;
      $display("FAIL mem_rerun got %h want %h", ctl, FRZ);
    end
    tick();
    idle();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== FRZ) begin
        errors++;
        $display("FAIL tmo_freeze%0d got %h want %h", i, ctl, FRZ);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({ctl, mem_error} !== {HLT, 1'b1}) begin
        errors++;
        $display("FAIL halt%0d got ctl=%h err=%b want %h err=1",
                 i, ctl, mem_error, HLT);
      end
      mem_ack = 1'b1;
      tick();
    end
    checks++;
    if (stall_cycles !== 4'd4) begin
      errors++;
      $display("FAIL halt_stall got %0d want 4", stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ctl, mem_error, stall_cycles, flush_count} !==
        {RST, 1'b0, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL halt_reset got ctl=%h err=%b st=%0d fl=%0d",
               ctl, mem_error, stall_cycles, flush_count);
    end
    rst_n = 1'b1;
    idle();
    #1;
    checks++;
    if (ctl !== DEF) begin
      errors++;
      $display("FAIL halt_to_run got %h want %h", ctl, DEF);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (stall_cycles !== 4'd14) begin
      errors++;
      $display("FAIL stall_14 got %0d want 14", stall_cycles);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat got %0d want 15", stall_cycles);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    checks++;
    if ({flush_count, stall_cycles} !== {4'd15, 4'd0}) begin
      errors++;
      $display("FAIL flush_sat got fl=%0d st=%0d want fl=15 st=0",
               flush_count, stall_cycles);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_rs2();
    test_branch_over_load_use();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the five-stage RISC-V pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-register write enables, flush controls and a MEM/WB bubble from:
  - load-use hazards,
  - taken branches,
  - a handshaked multi-cycle data memory.
- Contains a small FSM for memory wait and timeout, plus saturating stall and flush counters for performance observation.

Parameters:
- reg_addr_bits, 5: register-file address width.
- count_bits, 16: width of the stall and flush counters.
- mem_timeout, 64: maximum cycles in MEM_WAIT before entering HALT. Legal range 1..2^count_bits-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  reg_addr_bits  rs1 of the instruction in IF/ID.
- id_rs2  in  reg_addr_bits  rs2 of the instruction in IF/ID.
- id_uses_rs2  in  1  IF/ID instruction reads rs2.
- ex_rd  in  reg_addr_bits  rd of the instruction in ID/EX.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  EX/MEM instruction accesses data memory.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID capture enable.
- if_id_flush  out  1  IF/ID captures a NOP.
- id_ex_write  out  1  ID/EX capture enable.
- id_ex_flush  out  1  ID/EX captures zero control.
- ex_mem_write  out  1  EX/MEM capture enable.
- mem_wb_write  out  1  MEM/WB capture enable.
- mem_wb_bubble  out  1  MEM/WB captures zero control (RegWrite=0).
- mem_error  out  1  sticky memory-timeout flag.
- stall_cycles  out  count_bits  saturating count of cycles with pc_write=0.
- flush_count  out  count_bits  saturating count of branch flushes.

Behaviour:
- States are RUN, MEM_WAIT and HALT. The state, a wait counter, mem_error and both counters are registered. Control outputs are combinational from the current state and inputs (zero latency).
- While rst_n=0, and asynchronously:
  - state=RUN, wait counter=0, mem_error=0, stall_cycles=0, flush_count=0.
  - All *_write=0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
- Reset asserted mid-MEM_WAIT or in HALT returns to RUN at once.
- Default (no event): all *_write=1, all flushes=0, bubble=0.
- RUN priority, highest first:
  1. Memory stall, when mem_req=1 and mem_ack=0:
     - pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_bubble=1, mem_wb_write=1.
     - Next state MEM_WAIT; wait counter=1.
  2. Branch, when ex_branch_taken=1:
     - pc_write=1, if_id_flush=1, id_ex_flush=1. Other enables stay at default.
     - flush_count increments.
  3. Load-use, when ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs1, or id_uses_rs2=1 and ex_rd==id_rs2):
     - pc_write=0, if_id_write=0, id_ex_flush=1. Other enables stay at default.
- mem_req=1 with mem_ack=1 in the same cycle causes no stall; rules 2 and 3 are evaluated normally.
- Branch and load-use together: branch wins, because the IF/ID instruction is squashed anyway.
- MEM_WAIT, mem_ack=0:
  - Outputs are the same as rule 1; the wait counter increments.
  - When the wait counter reaches mem_timeout, next state is HALT and mem_error is set.
- MEM_WAIT, mem_ack=1:
  - Outputs are computed exactly as in RUN with rule 1 suppressed; the branch and load-use rules apply.
  - Next state RUN; wait counter cleared.
- HALT:
  - All *_write=0, mem_wb_bubble=1, flushes=0.
  - Stays in HALT until reset; mem_error is held at 1.
- stall_cycles increments on every clock edge with pc_write=0 outside HALT and outside reset. It saturates at all-ones; it never wraps.
- flush_count saturates at all-ones.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles 0->1; next cycle (ex_mem_read=0) all defaults.
- rd=x0 and rs2 qualification:
  - ex_rd=0, id_rs1=0, ex_mem_read=1 -> no stall.
  - ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall.
  - ex_rd=7, id_rs2=7, id_uses_rs2=1 -> stall.
- Branch over load-use: ex_branch_taken=1 together with a load-use match -> pc_write=1, if_id_flush=1, id_ex_flush=1; flush_count=1; stall_cycles unchanged.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then ack -> 3 cycles of full freeze with mem_wb_bubble=1; ack cycle all enables=1; stall_cycles=3; state back in RUN.
- Timeout: mem_timeout=4, mem_req=1, ack never arrives -> HALT after 4 wait cycles; mem_error=1; all enables 0; rst_n pulse low -> RUN, mem_error=0, counters=0.
- Saturation: count_bits=4, 20 consecutive load-use cycles -> stall_cycles stops at 15.
